counter_sequencer: RTL and testbench

Command-side driver and checker for the modulo-N counter. It accepts high-level commands over a valid/ready handshake, expands each command into the counter's per-cycle opcode stream, and mirrors the counter in an internal reference model. It returns the final counter value, parity and a mismatch flag on a valid/ready response channel. It sits between the control/test logic and one counter instance.

---
 rtl/counter_sequencer_pkg.sv | 36 +++
 rtl/counter_ref_model.sv | 50 +++++
 rtl/counter_sequencer.sv | 151 +++++++++++++++
 tb/tb_counter_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the modulo-N counter and its command sequencer.
package counter_pkg;

  // Counter opcodes, shared with the counter itself
  localparam logic [2:0] OP_EMPTY = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_INC   = 3'd3;
  localparam logic [2:0] OP_DEC   = 3'd4;

  // High-level command encoding on the command channel
  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_INC  = 2'd1;
  localparam logic [1:0] CMD_DEC  = 2'd2;
  localparam logic [1:0] CMD_SEEK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Per-cycle counter opcode issued for a command; SEEK walks forward with INC
  function automatic logic [2:0] cmd_to_op(input logic [1:0] cmd);
    logic [2:0] opc;
    case (cmd)
      CMD_LOAD: opc = OP_LOAD;
      CMD_INC:  opc = OP_INC;
      CMD_DEC:  opc = OP_DEC;
      default:  opc = OP_INC;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Reference copy of the modulo-N counter, advanced by the same opcode stream.
module counter_ref_model
  import counter_pkg::*;
#(
  parameter int N     = 9,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] model
);

  // One extra bit so N == 2^WIDTH and the wrap arithmetic never overflow
  localparam logic [WIDTH:0] N_EXT   = (WIDTH+1)'(N);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] TWO_EXT = (WIDTH+1)'(2);

  logic [WIDTH:0] model_ext;
  logic [WIDTH:0] next_ext;

  // Next model value for the opcode currently presented to the counter
  always_comb begin
    model_ext = {1'b0, model};
    next_ext  = model_ext;
    case (opcode)
      OP_LOAD: next_ext = {1'b0, data} % N_EXT;
      OP_INC:  next_ext = (model_ext >= N_EXT - ONE_EXT) ? '0 : model_ext + ONE_EXT;
      OP_DEC: begin
        if (model_ext == '0)
          next_ext = N_EXT - TWO_EXT;
        else if (model_ext == ONE_EXT)
          next_ext = N_EXT - ONE_EXT;
        else
          next_ext = model_ext - TWO_EXT;
      end
      default: next_ext = model_ext;
    endcase
  end

  // Model register, updated on the same edge the counter updates
  always_ff @(posedge clk) begin
    if (reset)
      model <= '0;
    else
      model <= next_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/counter_sequencer.sv
// Expands LOAD/INC/DEC/SEEK commands into counter opcodes, checks the counter
// against a reference model and reports the final value on a response channel.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int N     = 9,
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_count,
  output logic             ctr_enable,
  output logic [2:0]       ctr_opcode,
  output logic [WIDTH-1:0] ctr_data,
  input  logic [WIDTH-1:0] ctr_result,
  input  logic             ctr_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_parity,
  output logic             rsp_error,
  output logic             busy
);

  localparam logic [WIDTH:0] N_EXT   = (WIDTH+1)'(N);
  localparam logic [CNTW-1:0] ONE_CNT = CNTW'(1);

  state_t            state;
  logic [1:0]        op_q;
  logic [CNTW-1:0]   remaining;
  logic [CNTW-1:0]   rem_start;
  logic              err_acc;
  logic              chk_en;
  logic              mismatch;
  logic [WIDTH-1:0]  model;

  // Forward INC steps from cur to target mod N, computed one bit wider
  function automatic logic [WIDTH:0] seek_steps(input logic [WIDTH-1:0] target,
                                                input logic [WIDTH-1:0] cur);
    logic [WIDTH:0] tgt;
    logic [WIDTH:0] diff;
    tgt  = {1'b0, target} % N_EXT;
    diff = tgt + (N_EXT - {1'b0, cur});
    if (diff >= N_EXT)
      diff = diff - N_EXT;
    return diff;
  endfunction

  counter_ref_model #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_model (
    .clk    (clk),
    .reset  (reset),
    .opcode (ctr_opcode),
    .data   (ctr_data),
    .model  (model)
  );

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Counter disagrees with the model, or its parity output is inconsistent
  always_comb begin
    mismatch = 1'b0;
    if (chk_en)
      mismatch = (ctr_result != model) || (ctr_y != ~ctr_result[0]);
  end

  // Number of opcode cycles the offered command will take
  always_comb begin
    rem_start = '0;
    case (cmd_op)
      CMD_LOAD: rem_start = ONE_CNT;
      CMD_INC:  rem_start = cmd_count;
      CMD_DEC:  rem_start = cmd_count;
      default:  rem_start = CNTW'(seek_steps(cmd_data, model));
    endcase
  end

  // Command FSM with registered counter-side and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ctr_enable <= 1'b0;
      ctr_opcode <= OP_EMPTY;
      ctr_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_value  <= '0;
      rsp_parity <= 1'b0;
      rsp_error  <= 1'b0;
      err_acc    <= 1'b0;
      chk_en     <= 1'b0;
      op_q       <= CMD_LOAD;
      remaining  <= '0;
    end else begin
      ctr_enable <= 1'b1;
      chk_en     <= 1'b1;
      if (mismatch && state != S_IDLE)
        err_acc <= 1'b1;
      case (state)
        S_IDLE: begin
          ctr_opcode <= OP_EMPTY;
          if (cmd_valid) begin
            op_q      <= cmd_op;
            ctr_data  <= cmd_data;
            err_acc   <= 1'b0;
            remaining <= rem_start;
            if (rem_start != '0) begin
              state      <= S_ISSUE;
              ctr_opcode <= cmd_to_op(cmd_op);
            end else begin
              state      <= S_SETTLE;
              ctr_opcode <= OP_STOP;
            end
          end
        end
        S_ISSUE: begin
          remaining <= remaining - ONE_CNT;
          if (remaining == ONE_CNT) begin
            state      <= S_SETTLE;
            ctr_opcode <= OP_STOP;
          end else begin
            ctr_opcode <= cmd_to_op(op_q);
          end
        end
        S_SETTLE: begin
          rsp_value  <= ctr_result;
          rsp_parity <= ctr_y;
          rsp_error  <= err_acc | mismatch;
          rsp_valid  <= 1'b1;
          ctr_opcode <= OP_EMPTY;
          state      <= S_RESP;
        end
        default: begin
          ctr_opcode <= OP_EMPTY;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural modulo-9 counter.
module tb_counter_sequencer;

  localparam int NMOD = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_count;
  logic       ctr_enable;
  logic [2:0] ctr_opcode;
  logic [3:0] ctr_data;
  logic [3:0] ctr_result;
  logic       ctr_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_value;
  logic       rsp_parity;
  logic       rsp_error;
  logic       busy;

  logic [3:0] cnt;
  logic [3:0] fault = 4'd0;
  logic [3:0] trace [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] count;
    logic [3:0] ev;
    logic       ep;
    logic       ee;
    int         el;
  } vec_t;

  vec_t tbl [16];

  counter_sequencer #(.N(9), .WIDTH(4), .CNTW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .ctr_enable (ctr_enable),
    .ctr_opcode (ctr_opcode),
    .ctr_data   (ctr_data),
    .ctr_result (ctr_result),
    .ctr_y      (ctr_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_value  (rsp_value),
    .rsp_parity (rsp_parity),
    .rsp_error  (rsp_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural modulo-9 counter: enable low clears, DEC steps by two
  function automatic logic [3:0] ctr_next(input logic [3:0] v, input logic [2:0] opc,
                                          input logic [3:0] d);
    int iv;
    iv = int'(v);
    case (opc)
      3'd1: iv = int'(d) % NMOD;
      3'd3: iv = (iv >= NMOD - 1) ? 0 : iv + 1;
      3'd4: iv = (iv == 0) ? NMOD - 2 : (iv == 1) ? NMOD - 1 : iv - 2;
      default: iv = iv;
    endcase
    return 4'(iv);
  endfunction

  // Counter register
  always_ff @(posedge clk) begin
    cnt <= ctr_enable ? ctr_next(cnt, ctr_opcode, ctr_data) : 4'd0;
  end

  assign ctr_result = cnt + fault;
  assign ctr_y      = ~cnt[0];

  function automatic vec_t mk(input int op, input int data, input int count,
                              input int ev, input int ep, input int ee, input int el);
    vec_t v;
    v.op = 2'(op); v.data = 4'(data); v.count = 8'(count);
    v.ev = 4'(ev); v.ep = 1'(ep); v.ee = 1'(ee); v.el = el;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one command, measure latency, check the response, then consume it
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input logic [7:0] count, input logic [3:0] ev, input logic ep,
                         input logic ee, input int el, input int fault_at, input int hold);
    int  n;
    bit  got;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (n < 32) trace[n] = ctr_result;
      if (fault_at != 0) fault = (n == fault_at) ? 4'd1 : 4'd0;
      got = rsp_valid;
    end
    fault = 4'd0;
    check({tag, "_latency"}, n, el);
    check({tag, "_value"}, int'(rsp_value), int'(ev));
    check({tag, "_parity"}, int'(rsp_parity), int'(ep));
    check({tag, "_error"}, int'(rsp_error), int'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(rsp_valid), 1);
      check({tag, "_hold_value"}, int'(rsp_value), int'(ev));
      check({tag, "_hold_parity"}, int'(rsp_parity), int'(ep));
      check({tag, "_hold_cmd_ready"}, int'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, int'(rsp_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 4'd0;
    cmd_count = 8'd0;
    rsp_ready = 1'b0;

    tbl[0]  = mk(0, 13, 0, 4, 1, 0, 3);
    tbl[1]  = mk(1, 0, 6, 1, 0, 0, 8);
    tbl[2]  = mk(1, 0, 0, 1, 0, 0, 2);
    tbl[3]  = mk(2, 0, 3, 4, 1, 0, 5);
    tbl[4]  = mk(3, 2, 0, 2, 1, 0, 9);
    tbl[5]  = mk(3, 11, 0, 2, 1, 0, 2);
    tbl[6]  = mk(0, 8, 0, 8, 1, 0, 3);
    tbl[7]  = mk(2, 0, 1, 6, 1, 0, 3);
    tbl[8]  = mk(2, 0, 4, 7, 0, 0, 6);
    tbl[9]  = mk(1, 0, 2, 0, 1, 0, 4);
    tbl[10] = mk(3, 15, 0, 6, 1, 0, 8);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 3);
    tbl[12] = mk(2, 0, 1, 7, 0, 0, 3);
    tbl[13] = mk(2, 0, 2, 3, 0, 0, 4);
    tbl[14] = mk(3, 0, 0, 0, 1, 0, 8);
    tbl[15] = mk(0, 15, 0, 6, 1, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctr_enable", int'(ctr_enable), 0);
    check("reset_ctr_opcode", int'(ctr_opcode), 0);
    check("reset_ctr_data", int'(ctr_data), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_value", int'(rsp_value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, tbl[i].count,
              tbl[i].ev, tbl[i].ep, tbl[i].ee, tbl[i].el, 0, 0);
    end

    // INC sequence 5,6,7,8,0,1 seen on the counter from a value of 4
    run_cmd("seq_load", 2'd0, 4'd4, 8'd0, 4'd4, 1'b1, 1'b0, 3, 0, 0);
    run_cmd("seq_inc", 2'd1, 4'd0, 8'd6, 4'd1, 1'b0, 1'b0, 8, 0, 0);
    check("seq_step1", int'(trace[2]), 5);
    check("seq_step2", int'(trace[3]), 6);
    check("seq_step3", int'(trace[4]), 7);
    check("seq_step4", int'(trace[5]), 8);
    check("seq_step5", int'(trace[6]), 0);
    check("seq_step6", int'(trace[7]), 1);

    // One-cycle corrupted counter value raises error; next command is clean
    run_cmd("fault_inc", 2'd1, 4'd0, 8'd2, 4'd3, 1'b0, 1'b1, 4, 2, 0);
    run_cmd("clean_inc", 2'd1, 4'd0, 8'd1, 4'd4, 1'b1, 1'b0, 3, 0, 0);

    // Response back-pressure for five cycles
    run_cmd("hold_dec", 2'd2, 4'd0, 8'd1, 4'd2, 1'b1, 1'b0, 3, 0, 5);

    // Reset in the middle of an INC burst abandons the command
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_count = 8'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midreset_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_ctr_enable", int'(ctr_enable), 0);
    check("midreset_rsp_valid", int'(rsp_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_model", int'(dut.u_model.model), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midreset_no_response", seen, 0);
    run_cmd("post_load", 2'd0, 4'd3, 8'd0, 4'd3, 1'b0, 1'b0, 3, 0, 0);
    run_cmd("post_inc", 2'd1, 4'd0, 8'd1, 4'd4, 1'b1, 1'b0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
